// File: rtl/mac_pkg.sv
// Shared widths, accumulator mode and clamp-value helpers for the MAC pipeline.
package mac_pkg;

   localparam int DEF_A_W   = 16;
   localparam int DEF_B_W   = 16;
   localparam int DEF_ACC_W = 40;

   typedef enum logic {MAC_UNS = 1'b0, MAC_SGN = 1'b1} mac_mode_e;

   typedef struct packed {
      logic      load;
      mac_mode_e mode;
   } mac_ctrl_t;

   // Clamp values are returned 64 bits wide; callers keep the low acc_w bits.
   function automatic logic [63:0] sat_max(input int acc_w, input logic sgn);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < 64; i++)
         if (i < (sgn ? acc_w - 1 : acc_w)) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [63:0] sat_min(input int acc_w, input logic sgn);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < 64; i++)
         if (sgn && i == acc_w - 1) v[i] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mac_pipe_if.sv
// Sample stream into the MAC and the product/accumulator stream out of it.
interface mac_pipe_if #(
   parameter int A_W   = 16,
   parameter int B_W   = 16,
   parameter int ACC_W = 40
);
   logic                 ce;
   logic                 in_valid;
   logic [A_W-1:0]       a;
   logic [B_W-1:0]       b;
   logic                 a_signed;
   logic                 b_signed;
   logic                 acc_load;
   logic                 ovf_clr;
   logic                 out_valid;
   logic [A_W+B_W-1:0]   prod;
   logic [ACC_W-1:0]     acc;
   logic                 ovf;

   modport master (
      output ce, in_valid, a, b, a_signed, b_signed, acc_load, ovf_clr,
      input  out_valid, prod, acc, ovf
   );

   modport slave (
      input  ce, in_valid, a, b, a_signed, b_signed, acc_load, ovf_clr,
      output out_valid, prod, acc, ovf
   );
endinterface

// File: rtl/mac_mult_core.sv
// Operand register plus product register; the one-bit-wider operands make every
// signed/unsigned mix an ordinary signed multiply.
module mac_mult_core #(
   parameter int A_W = 16,
   parameter int B_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ce,
   input  logic [A_W-1:0]       a,
   input  logic [B_W-1:0]       b,
   input  logic                 a_signed,
   input  logic                 b_signed,
   output logic [A_W+B_W-1:0]   p
);
   localparam int P_W = A_W + B_W;

   logic [A_W:0]   a_x;
   logic [B_W:0]   b_x;
   logic [P_W-1:0] a_e, b_e, p_t;

   // Truncating to P_W bits is exact, so the product is formed modulo 2^P_W.
   assign a_e = {{(B_W-1){a_x[A_W]}}, a_x};
   assign b_e = {{(A_W-1){b_x[B_W]}}, b_x};
   assign p_t = a_e * b_e;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_x <= '0;
         b_x <= '0;
         p   <= '0;
      end else if (ce) begin
         a_x <= {a[A_W-1] & a_signed, a};
         b_x <= {b[B_W-1] & b_signed, b};
         p   <= p_t;
      end
   end
endmodule

// File: rtl/mac_pipe.sv
// Three-stage multiply-accumulate: S1/S2 in mac_mult_core, S3 accumulate with
// optional saturation and a sticky overflow flag.
module mac_pipe
   import mac_pkg::*;
#(
   parameter int A_W   = DEF_A_W,
   parameter int B_W   = DEF_B_W,
   parameter int ACC_W = DEF_ACC_W,
   parameter int SAT   = 1
) (
   input logic       clk,
   input logic       reset_n,
   mac_pipe_if.slave bus
);
   localparam int P_W    = A_W + B_W;
   localparam int STAGES = 2;
   localparam logic [63:0] SMAX_W = sat_max(ACC_W, 1'b1);
   localparam logic [63:0] SMIN_W = sat_min(ACC_W, 1'b1);
   localparam logic [63:0] UMAX_W = sat_max(ACC_W, 1'b0);

   logic [STAGES:0]  vld_pipe;
   mac_ctrl_t [1:0]  ctrl_pipe;
   mac_ctrl_t        ctrl_in;
   logic [P_W-1:0]   p2, prod_q;
   logic [ACC_W-1:0] acc_q, p_ext, sat_val, acc_nxt;
   logic [ACC_W:0]   sum;
   logic             sgn3, ovf_det, ovf_set, ovf_q;

   always_comb begin
      ctrl_in      = '0;
      ctrl_in.load = bus.acc_load;
      ctrl_in.mode = (bus.a_signed | bus.b_signed) ? MAC_SGN : MAC_UNS;
   end

   mac_mult_core #(.A_W(A_W), .B_W(B_W)) u_mult (
      .clk      (clk),
      .reset_n  (reset_n),
      .ce       (bus.ce),
      .a        (bus.a),
      .b        (bus.b),
      .a_signed (bus.a_signed),
      .b_signed (bus.b_signed),
      .p        (p2)
   );

   // The mode travelling with the sample decides both extension and overflow rule.
   always_comb begin
      sgn3  = (ctrl_pipe[1].mode == MAC_SGN);
      p_ext = sgn3 ? {{(ACC_W-P_W){p2[P_W-1]}}, p2} : {{(ACC_W-P_W){1'b0}}, p2};
      sum   = {1'b0, acc_q} + {1'b0, p_ext};
      if (sgn3) begin
         ovf_det = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
         sat_val = acc_q[ACC_W-1] ? SMIN_W[ACC_W-1:0] : SMAX_W[ACC_W-1:0];
      end else begin
         ovf_det = sum[ACC_W];
         sat_val = UMAX_W[ACC_W-1:0];
      end
      if (ctrl_pipe[1].load)
         acc_nxt = p_ext;
      else if (ovf_det && SAT != 0)
         acc_nxt = sat_val;
      else
         acc_nxt = sum[ACC_W-1:0];
   end

   assign ovf_set = bus.ce & vld_pipe[1] & ~ctrl_pipe[1].load & ovf_det;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe  <= '0;
         ctrl_pipe <= '0;
         prod_q    <= '0;
         acc_q     <= '0;
      end else if (bus.ce) begin
         vld_pipe     <= {vld_pipe[STAGES-1:0], bus.in_valid};
         ctrl_pipe[0] <= ctrl_in;
         ctrl_pipe[1] <= ctrl_pipe[0];
         if (vld_pipe[1]) begin
            prod_q <= p2;
            acc_q  <= acc_nxt;
         end
      end
   end

   // Clear works even while stalled; a same-cycle overflow keeps the flag set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         ovf_q <= 1'b0;
      else if (ovf_set)     ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
   end

   assign bus.out_valid = vld_pipe[STAGES];
   assign bus.prod      = prod_q;
   assign bus.acc       = acc_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mac_pipe.sv
// Directed scoreboard bench: 40-bit saturating unit plus 33-bit saturating and wrapping units.
module tb_mac_pipe;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mac_pipe_if #(.A_W(16), .B_W(16), .ACC_W(40)) m_if ();
   mac_pipe_if #(.A_W(16), .B_W(16), .ACC_W(33)) s_if ();
   mac_pipe_if #(.A_W(16), .B_W(16), .ACC_W(33)) w_if ();

   assign w_if.ce       = s_if.ce;
   assign w_if.in_valid = s_if.in_valid;
   assign w_if.a        = s_if.a;
   assign w_if.b        = s_if.b;
   assign w_if.a_signed = s_if.a_signed;
   assign w_if.b_signed = s_if.b_signed;
   assign w_if.acc_load = s_if.acc_load;
   assign w_if.ovf_clr  = s_if.ovf_clr;

   mac_pipe #(.A_W(16), .B_W(16), .ACC_W(40), .SAT(1)) u_m (.clk(clk), .reset_n(reset_n), .bus(m_if.slave));
   mac_pipe #(.A_W(16), .B_W(16), .ACC_W(33), .SAT(1)) u_s (.clk(clk), .reset_n(reset_n), .bus(s_if.slave));
   mac_pipe #(.A_W(16), .B_W(16), .ACC_W(33), .SAT(0)) u_w (.clk(clk), .reset_n(reset_n), .bus(w_if.slave));

   typedef struct {
      logic [31:0] prod;
      logic [63:0] acc;
      logic        ovf;
   } exp_t;

   exp_t m_q[$];
   exp_t s_q[$];
   exp_t w_q[$];
   int   tests = 0;
   int   fails = 0;
   int   max_run = 0;
   int   n;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic idle(input int cyc);
      repeat (cyc) @(posedge clk);
      #1;
   endtask

   task automatic m_send(input logic [15:0] a, input logic [15:0] b, input logic as, input logic bs,
                         input logic ld, input logic push, input logic [31:0] ep, input logic [63:0] ea);
      m_if.in_valid = 1'b1;
      m_if.a = a; m_if.b = b; m_if.a_signed = as; m_if.b_signed = bs; m_if.acc_load = ld;
      if (push) m_q.push_back('{prod: ep, acc: ea, ovf: 1'b0});
      @(posedge clk); #1;
      m_if.in_valid = 1'b0;
   endtask

   // Both operands signed; the same sample goes to the saturating and the wrapping unit.
   task automatic s_send(input logic [15:0] a, input logic [15:0] b, input logic ld, input logic [31:0] ep,
                         input logic [63:0] sa, input logic so, input logic [63:0] wa, input logic wo);
      s_if.in_valid = 1'b1;
      s_if.a = a; s_if.b = b; s_if.a_signed = 1'b1; s_if.b_signed = 1'b1; s_if.acc_load = ld;
      s_q.push_back('{prod: ep, acc: sa, ovf: so});
      w_q.push_back('{prod: ep, acc: wa, ovf: wo});
      @(posedge clk); #1;
      s_if.in_valid = 1'b0;
   endtask

   // Counts edges since the sample was driven until out_valid is seen.
   task automatic wait_out(input int start, output int cnt);
      cnt = start;
      while (cnt < 20) begin
         @(negedge clk);
         if (m_if.out_valid) break;
         @(posedge clk);
         cnt++;
      end
   endtask

   initial begin : mon_m
      logic c;
      exp_t e;
      int   run;
      run = 0;
      forever begin
         @(posedge clk); c = m_if.ce;
         @(negedge clk);
         if (m_if.out_valid) run++; else run = 0;
         if (run > max_run) max_run = run;
         if (c && m_if.out_valid) begin
            if (m_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL m_unexpected: out_valid=1 acc=%0h, no output expected", m_if.acc);
            end else begin
               e = m_q.pop_front();
               chk("m_prod", m_if.prod, e.prod);
               chk("m_acc", m_if.acc, e.acc);
               chk("m_ovf", m_if.ovf, e.ovf);
            end
         end
      end
   end

   initial begin : mon_s
      logic c;
      exp_t e;
      forever begin
         @(posedge clk); c = s_if.ce;
         @(negedge clk);
         if (c && s_if.out_valid) begin
            if (s_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL s_unexpected: out_valid=1 acc=%0h, no output expected", s_if.acc);
            end else begin
               e = s_q.pop_front();
               chk("s_prod", s_if.prod, e.prod);
               chk("s_acc", s_if.acc, e.acc);
               chk("s_ovf", s_if.ovf, e.ovf);
            end
         end
      end
   end

   initial begin : mon_w
      logic c;
      exp_t e;
      forever begin
         @(posedge clk); c = w_if.ce;
         @(negedge clk);
         if (c && w_if.out_valid) begin
            if (w_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL w_unexpected: out_valid=1 acc=%0h, no output expected", w_if.acc);
            end else begin
               e = w_q.pop_front();
               chk("w_prod", w_if.prod, e.prod);
               chk("w_acc", w_if.acc, e.acc);
               chk("w_ovf", w_if.ovf, e.ovf);
            end
         end
      end
   end

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      m_if.ce = 1'b1; m_if.in_valid = 1'b0; m_if.a = '0; m_if.b = '0;
      m_if.a_signed = 1'b0; m_if.b_signed = 1'b0; m_if.acc_load = 1'b0; m_if.ovf_clr = 1'b0;
      s_if.ce = 1'b1; s_if.in_valid = 1'b0; s_if.a = '0; s_if.b = '0;
      s_if.a_signed = 1'b0; s_if.b_signed = 1'b0; s_if.acc_load = 1'b0; s_if.ovf_clr = 1'b0;

      repeat (2) @(posedge clk);
      #2;
      chk("rst_valid", m_if.out_valid, 0);
      chk("rst_prod", m_if.prod, 0);
      chk("rst_acc", m_if.acc, 0);
      chk("rst_ovf", m_if.ovf, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // signed and mixed-mode products
      m_send(16'hFFFD, 16'd7, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFEB, 64'hFF_FFFF_FFEB);
      wait_out(1, n);
      chk("lat_signed", n, 3);
      idle(4);
      m_send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_0001, 64'hFF_FFFF_0001);
      idle(5);

      // back-to-back accumulation
      max_run = 0;
      m_send(16'd100, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1, 32'd200, 64'd200);
      m_send(16'd100, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'd200, 64'd400);
      m_send(16'd100, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'd200, 64'd600);
      m_send(16'd100, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'd200, 64'd800);
      m_send(16'd100, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'd200, 64'd1000);
      idle(6);
      chk("acc_run", max_run, 5);

      // stall: two ce=0 cycles, with an ignored sample offered meanwhile
      m_send(16'd12, 16'hFFFB, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFC4, 64'hFF_FFFF_FFC4);
      m_if.ce = 1'b0; m_if.in_valid = 1'b1; m_if.a = 16'd9; m_if.b = 16'd9; m_if.acc_load = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      m_if.ce = 1'b1; m_if.in_valid = 1'b0;
      wait_out(3, n);
      chk("stall_lat", n, 5);
      idle(5);

      // saturation vs wrap at ACC_W=33: build 2^32-1-100, then add 32767^2
      s_send(16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001, 64'd1073676289, 1'b0, 64'd1073676289, 1'b0);
      s_send(16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF_0001, 64'd2147352578, 1'b0, 64'd2147352578, 1'b0);
      s_send(16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF_0001, 64'd3221028867, 1'b0, 64'd3221028867, 1'b0);
      s_send(16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF_0001, 64'd4294705156, 1'b0, 64'd4294705156, 1'b0);
      s_send(16'd511, 16'd512, 1'b0, 32'd261632, 64'd4294966788, 1'b0, 64'd4294966788, 1'b0);
      s_send(16'd11, 16'd37, 1'b0, 32'd407, 64'd4294967195, 1'b0, 64'd4294967195, 1'b0);
      s_send(16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF_0001, 64'd4294967295, 1'b1, 64'd5368643484, 1'b1);
      idle(5);
      chk("s_ovf_sticky", s_if.ovf, 1);
      chk("w_ovf_sticky", w_if.ovf, 1);

      // ovf_clr alone, then ovf_clr on the same edge as an overflow
      s_if.ovf_clr = 1'b1;
      @(posedge clk); #1;
      s_if.ovf_clr = 1'b0;
      chk("s_ovf_clr", s_if.ovf, 0);
      chk("w_ovf_clr", w_if.ovf, 0);
      s_send(16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF_0001, 64'd4294967295, 1'b1, 64'd6442319773, 1'b0);
      @(posedge clk); #1;
      s_if.ovf_clr = 1'b1;
      @(posedge clk); #1;
      s_if.ovf_clr = 1'b0;
      idle(3);
      chk("s_ovf_setwins", s_if.ovf, 1);

      // reset with three samples in flight
      m_send(16'd3, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 64'd0);
      m_send(16'd4, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
      m_send(16'd5, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
      #1;
      chk("rst_pre_valid", m_if.out_valid, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_valid", m_if.out_valid, 0);
      chk("rst_mid_acc", m_if.acc, 0);
      chk("rst_mid_prod", m_if.prod, 0);
      chk("rst_mid_s_acc", s_if.acc, 0);
      chk("rst_mid_s_ovf", s_if.ovf, 0);
      chk("rst_mid_w_acc", w_if.acc, 0);
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      idle(6);
      m_send(16'd5, 16'd6, 1'b0, 1'b0, 1'b0, 1'b1, 32'd30, 64'd30);
      idle(6);

      chk("m_q_empty", m_q.size(), 0);
      chk("s_q_empty", s_q.size(), 0);
      chk("w_q_empty", w_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
